// File: rtl/fdk_regbank_slave.sv
// FDK register bank: local ID/CTRL/STATUS/CMD/TRIG registers behind a req/ack
// host bus, with upper-half addresses forwarded to an external section port.
module fdk_regbank_slave #(
  parameter int unsigned ADDR_W      = 10,
  parameter logic [31:0] ID_VALUE    = 32'h0A7E_0001,
  parameter int unsigned EXT_TIMEOUT = 64
) (
  input  logic              sys_clk,
  input  logic              sys_reset_n,
  input  logic              host_req,
  input  logic              host_rnw,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [31:0]       host_wdata,
  output logic              host_ack,
  output logic [31:0]       host_rdata,
  output logic              host_err,
  output logic [31:0]       ctrl_o,
  output logic [7:0]        cmd_o,
  input  logic [7:0]        cmd_done_i,
  input  logic [7:0]        event_i,
  output logic [7:0]        trig_o,
  output logic              ext_req,
  output logic              ext_rnw,
  output logic [ADDR_W-2:0] ext_addr,
  output logic [31:0]       ext_wdata,
  input  logic              ext_ack,
  input  logic [31:0]       ext_rdata
);

  localparam int unsigned CNT_W = $clog2(EXT_TIMEOUT + 1);
  localparam int unsigned OFS_W = ADDR_W - 3;

  localparam logic [OFS_W-1:0] OFS_ID     = OFS_W'(0);
  localparam logic [OFS_W-1:0] OFS_CTRL   = OFS_W'(1);
  localparam logic [OFS_W-1:0] OFS_STATUS = OFS_W'(2);
  localparam logic [OFS_W-1:0] OFS_CMD    = OFS_W'(3);
  localparam logic [OFS_W-1:0] OFS_TRIG   = OFS_W'(4);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXT_WAIT = 2'd1,
    DONE     = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ack_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              ext_req_q;
  logic              ext_rnw_q;
  logic [ADDR_W-2:0] ext_addr_q;
  logic [31:0]       ext_wdata_q;

  logic [31:0] ctrl_q,   ctrl_d;
  logic [7:0]  status_q, status_d;
  logic [7:0]  cmd_q,    cmd_d;
  logic [7:0]  trig_q,   trig_d;

  logic [OFS_W-1:0] word_ofs;
  logic             wr_en;
  logic [31:0]      int_rdata;
  logic             int_err;
  logic [7:0]       status_clr;
  logic [7:0]       cmd_set;

  // Word offset inside the lower half; the two byte-lane bits are don't-care.
  assign word_ofs = host_addr[ADDR_W-2:2];
  assign wr_en    = (state_q == IDLE) && host_req && !host_addr[ADDR_W-1] && !host_rnw;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    int_rdata = '0;
    int_err   = 1'b0;
    case (word_ofs)
      OFS_ID:     int_rdata = ID_VALUE;
      OFS_CTRL:   int_rdata = ctrl_q;
      OFS_STATUS: int_rdata = {24'd0, status_q};
      OFS_CMD:    int_rdata = {24'd0, cmd_q};
      OFS_TRIG:   int_rdata = '0;
      default:    int_err   = 1'b1;
    endcase
  end

  // Set/clear ordering encodes the conflict rules: a core event beats a host
  // clear on STATUS, a host set beats a core done on CMD.
  always_comb begin
    ctrl_d     = ctrl_q;
    status_clr = '0;
    cmd_set    = '0;
    trig_d     = '0;
    if (wr_en) begin
      case (word_ofs)
        OFS_CTRL:   ctrl_d     = host_wdata;
        OFS_STATUS: status_clr = host_wdata[7:0];
        OFS_CMD:    cmd_set    = host_wdata[7:0];
        OFS_TRIG:   trig_d     = host_wdata[7:0];
        default:    ;
      endcase
    end
    status_d = (status_q & ~status_clr) | event_i;
    cmd_d    = (cmd_q & ~cmd_done_i) | cmd_set;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      ctrl_q   <= '0;
      status_q <= '0;
      cmd_q    <= '0;
      trig_q   <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      status_q <= status_d;
      cmd_q    <= cmd_d;
      trig_q   <= trig_d;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      ext_req_q   <= 1'b0;
      ext_rnw_q   <= 1'b0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
    end else begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (host_req) begin
            if (host_addr[ADDR_W-1]) begin
              state_q     <= EXT_WAIT;
              cnt_q       <= '0;
              ext_req_q   <= 1'b1;
              ext_rnw_q   <= host_rnw;
              ext_addr_q  <= host_addr[ADDR_W-2:0];
              ext_wdata_q <= host_wdata;
            end else begin
              state_q <= DONE;
              ack_q   <= 1'b1;
              rdata_q <= host_rnw ? int_rdata : '0;
              err_q   <= int_err;
            end
          end
        end
        EXT_WAIT: begin
          if (ext_ack) begin
            state_q   <= DONE;
            ext_req_q <= 1'b0;
            ack_q     <= 1'b1;
            rdata_q   <= ext_rnw_q ? ext_rdata : '0;
          end else if (cnt_q == CNT_W'(EXT_TIMEOUT)) begin
            state_q   <= DONE;
            ext_req_q <= 1'b0;
            ack_q     <= 1'b1;
            rdata_q   <= 32'hDEAD_BEEF;
            err_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        // Ack is already on the wire; host_req is deliberately not sampled here.
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign host_ack   = ack_q;
  assign host_rdata = rdata_q;
  assign host_err   = err_q;
  assign ctrl_o     = ctrl_q;
  assign cmd_o      = cmd_q;
  assign trig_o     = trig_q;
  assign ext_req    = ext_req_q;
  assign ext_rnw    = ext_rnw_q;
  assign ext_addr   = ext_addr_q;
  assign ext_wdata  = ext_wdata_q;

endmodule

// File: tb/tb_fdk_regbank_slave.sv
// Self-checking bench for fdk_regbank_slave: per-feature tasks, expected
// responses queued at request time and compared when host_ack arrives.
module tb_fdk_regbank_slave;

  localparam int          ADDR_W      = 10;
  localparam int          EXT_TIMEOUT = 64;
  localparam logic [31:0] ID_VALUE    = 32'h0A7E_0001;
  localparam int          MAX_WAIT    = 3 * EXT_TIMEOUT;

  logic              clk = 1'b0;
  logic              sys_reset_n;
  logic              host_req;
  logic              host_rnw;
  logic [ADDR_W-1:0] host_addr;
  logic [31:0]       host_wdata;
  logic              host_ack;
  logic [31:0]       host_rdata;
  logic              host_err;
  logic [31:0]       ctrl_o;
  logic [7:0]        cmd_o;
  logic [7:0]        cmd_done_i;
  logic [7:0]        event_i;
  logic [7:0]        trig_o;
  logic              ext_req;
  logic              ext_rnw;
  logic [ADDR_W-2:0] ext_addr;
  logic [31:0]       ext_wdata;
  logic              ext_ack;
  logic [31:0]       ext_rdata;

  always #5 clk = ~clk;

  fdk_regbank_slave #(
    .ADDR_W     (ADDR_W),
    .ID_VALUE   (ID_VALUE),
    .EXT_TIMEOUT(EXT_TIMEOUT)
  ) dut (
    .sys_clk    (clk),
    .sys_reset_n(sys_reset_n),
    .host_req   (host_req),
    .host_rnw   (host_rnw),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .host_err   (host_err),
    .ctrl_o     (ctrl_o),
    .cmd_o      (cmd_o),
    .cmd_done_i (cmd_done_i),
    .event_i    (event_i),
    .trig_o     (trig_o),
    .ext_req    (ext_req),
    .ext_rnw    (ext_rnw),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_ack    (ext_ack),
    .ext_rdata  (ext_rdata)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  lat;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] trig_at_ack;
  logic [7:0] trig_after;

  // Pop the oldest expectation and compare it with the response on the bus.
  task automatic score(input bit acked, input int cyc, input string name);
    exp_t e;
    e = sb_q.pop_front();
    n_checks++;
    if (!acked) begin
      $display("FAIL %s: no host_ack within %0d cycles", name, cyc);
      n_errors++;
    end else begin
      if (8'(cyc) !== e.lat) begin
        $display("FAIL %s latency: got %0d cycles, want %0d", name, cyc, e.lat);
        n_errors++;
      end
      n_checks++;
      if (host_rdata !== e.rdata) begin
        $display("FAIL %s rdata: got %h, want %h", name, host_rdata, e.rdata);
        n_errors++;
      end
      n_checks++;
      if (host_err !== e.err) begin
        $display("FAIL %s err: got %b, want %b", name, host_err, e.err);
        n_errors++;
      end
    end
  endtask

  // Ack must last one cycle and rdata must return to 0 behind it.
  task automatic check_ack_drop(input string name);
    @(negedge clk);
    trig_after = trig_o;
    n_checks++;
    if ({host_ack, host_rdata, host_err} !== 34'd0) begin
      $display("FAIL %s ack_drop: got ack=%b rdata=%h err=%b, want all 0",
               name, host_ack, host_rdata, host_err);
      n_errors++;
    end
  endtask

  // Internal access; ev/done are pulsed in the same cycle the request is sampled.
  task automatic host_access(input logic rnw, input logic [ADDR_W-1:0] addr,
                             input logic [31:0] wdata, input logic [7:0] ev,
                             input logic [7:0] done, input logic [31:0] exp_rdata,
                             input logic exp_err, input string name);
    exp_t e;
    int   cyc;
    bit   acked;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = 8'd1;
    sb_q.push_back(e);
    @(negedge clk);
    host_req   = 1'b1;
    host_rnw   = rnw;
    host_addr  = addr;
    host_wdata = wdata;
    event_i    = ev;
    cmd_done_i = done;
    cyc   = 0;
    acked = 1'b0;
    while (!acked && cyc < MAX_WAIT) begin
      @(negedge clk);
      cyc++;
      event_i    = '0;
      cmd_done_i = '0;
      acked      = host_ack;
    end
    score(acked, cyc, name);
    trig_at_ack = trig_o;
    host_req    = 1'b0;
    check_ack_drop(name);
  endtask

  // External access; resp_delay = cycles after ext_req rises until ext_ack, 0 = no responder.
  task automatic ext_access(input logic rnw, input logic [ADDR_W-1:0] addr,
                            input logic [31:0] wdata, input int resp_delay,
                            input logic [31:0] resp_data, input logic [31:0] exp_rdata,
                            input logic exp_err, input int exp_lat, input string name);
    exp_t e;
    int   cyc;
    bit   acked;
    logic [ADDR_W-2:0] exp_ext_addr;
    exp_ext_addr = addr[ADDR_W-2:0];
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = 8'(exp_lat);
    sb_q.push_back(e);
    @(negedge clk);
    host_req   = 1'b1;
    host_rnw   = rnw;
    host_addr  = addr;
    host_wdata = wdata;
    cyc   = 0;
    acked = 1'b0;
    while (!acked && cyc < MAX_WAIT) begin
      @(negedge clk);
      cyc++;
      acked = host_ack;
      if (cyc == 1) begin
        n_checks++;
        if ({ext_req, ext_rnw, ext_addr, ext_wdata} !== {1'b1, rnw, exp_ext_addr, wdata}) begin
          $display("FAIL %s ext_qual: got req=%b rnw=%b addr=%h wdata=%h, want 1 %b %h %h",
                   name, ext_req, ext_rnw, ext_addr, ext_wdata, rnw, exp_ext_addr, wdata);
          n_errors++;
        end
      end
      if (!acked && resp_delay != 0 && cyc == resp_delay + 1) begin
        ext_ack   = 1'b1;
        ext_rdata = resp_data;
      end else begin
        ext_ack   = 1'b0;
        ext_rdata = '0;
      end
    end
    ext_ack   = 1'b0;
    ext_rdata = '0;
    score(acked, cyc, name);
    n_checks++;
    if (ext_req !== 1'b0) begin
      $display("FAIL %s ext_req_drop: got %b, want 0", name, ext_req);
      n_errors++;
    end
    host_req = 1'b0;
    check_ack_drop(name);
  endtask

  task automatic test_reset();
    sys_reset_n = 1'b0;
    host_req    = 1'b0;
    host_rnw    = 1'b0;
    host_addr   = '0;
    host_wdata  = '0;
    cmd_done_i  = '0;
    event_i     = '0;
    ext_ack     = 1'b0;
    ext_rdata   = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({host_ack, host_rdata, host_err, ext_req, ext_rnw, ext_addr, ext_wdata} !== '0) begin
      $display("FAIL reset_bus: got ack=%b rdata=%h err=%b ext_req=%b, want all 0",
               host_ack, host_rdata, host_err, ext_req);
      n_errors++;
    end
    n_checks++;
    if ({ctrl_o, cmd_o, trig_o} !== 48'd0) begin
      $display("FAIL reset_regs: got ctrl=%h cmd=%h trig=%h, want 0", ctrl_o, cmd_o, trig_o);
      n_errors++;
    end
    sys_reset_n = 1'b1;
  endtask

  task automatic test_id_ctrl();
    host_access(1'b1, 10'h000, 32'h0, 8'h00, 8'h00, ID_VALUE, 1'b0, "id_read");
    host_access(1'b0, 10'h000, 32'hFFFF_FFFF, 8'h00, 8'h00, 32'h0, 1'b0, "id_write");
    host_access(1'b1, 10'h000, 32'h0, 8'h00, 8'h00, ID_VALUE, 1'b0, "id_reread");
    host_access(1'b0, 10'h004, 32'h1234_5678, 8'h00, 8'h00, 32'h0, 1'b0, "ctrl_write");
    n_checks++;
    if (ctrl_o !== 32'h1234_5678) begin
      $display("FAIL ctrl_o: got %h, want 12345678", ctrl_o);
      n_errors++;
    end
    host_access(1'b1, 10'h007, 32'h0, 8'h00, 8'h00, 32'h1234_5678, 1'b0, "ctrl_read_lane_bits");
  endtask

  task automatic test_status();
    @(negedge clk);
    event_i = 8'h05;
    @(negedge clk);
    event_i = 8'h00;
    host_access(1'b1, 10'h008, 32'h0, 8'h00, 8'h00, 32'h05, 1'b0, "status_after_event");
    host_access(1'b0, 10'h008, 32'h0000_0001, 8'h00, 8'h00, 32'h0, 1'b0, "status_w1c");
    host_access(1'b1, 10'h008, 32'h0, 8'h00, 8'h00, 32'h04, 1'b0, "status_after_w1c");
    host_access(1'b0, 10'h008, 32'h0000_0004, 8'h04, 8'h00, 32'h0, 1'b0, "status_conflict");
    host_access(1'b1, 10'h008, 32'h0, 8'h00, 8'h00, 32'h04, 1'b0, "status_event_wins");
    host_access(1'b0, 10'h008, 32'hFFFF_FFFF, 8'h00, 8'h00, 32'h0, 1'b0, "status_clear_all");
    host_access(1'b1, 10'h008, 32'h0, 8'h00, 8'h00, 32'h00, 1'b0, "status_empty");
  endtask

  task automatic test_cmd();
    host_access(1'b0, 10'h00C, 32'h0000_0081, 8'h00, 8'h00, 32'h0, 1'b0, "cmd_w1s");
    n_checks++;
    if (cmd_o !== 8'h81) begin
      $display("FAIL cmd_o_set: got %h, want 81", cmd_o);
      n_errors++;
    end
    @(negedge clk);
    cmd_done_i = 8'h01;
    @(negedge clk);
    cmd_done_i = 8'h00;
    n_checks++;
    if (cmd_o !== 8'h80) begin
      $display("FAIL cmd_o_done: got %h, want 80", cmd_o);
      n_errors++;
    end
    host_access(1'b0, 10'h00C, 32'h0000_0080, 8'h00, 8'h80, 32'h0, 1'b0, "cmd_conflict");
    n_checks++;
    if (cmd_o !== 8'h80) begin
      $display("FAIL cmd_o_set_wins: got %h, want 80", cmd_o);
      n_errors++;
    end
    host_access(1'b1, 10'h00C, 32'h0, 8'h00, 8'h00, 32'h80, 1'b0, "cmd_read");
    @(negedge clk);
    cmd_done_i = 8'h80;
    @(negedge clk);
    cmd_done_i = 8'h00;
    n_checks++;
    if (cmd_o !== 8'h00) begin
      $display("FAIL cmd_o_cleared: got %h, want 00", cmd_o);
      n_errors++;
    end
  endtask

  task automatic test_trig_unmapped();
    host_access(1'b0, 10'h010, 32'h0000_00A5, 8'h00, 8'h00, 32'h0, 1'b0, "trig_write");
    n_checks++;
    if (trig_at_ack !== 8'hA5 || trig_after !== 8'h00) begin
      $display("FAIL trig_pulse: got %h then %h, want a5 then 00", trig_at_ack, trig_after);
      n_errors++;
    end
    host_access(1'b1, 10'h010, 32'h0, 8'h00, 8'h00, 32'h0, 1'b0, "trig_read");
    host_access(1'b1, 10'h014, 32'h0, 8'h00, 8'h00, 32'h0, 1'b1, "unmapped_read");
    host_access(1'b0, 10'h1FC, 32'hFFFF_FFFF, 8'h00, 8'h00, 32'h0, 1'b1, "unmapped_write");
    n_checks++;
    if (ctrl_o !== 32'h1234_5678 || cmd_o !== 8'h00) begin
      $display("FAIL unmapped_no_effect: got ctrl=%h cmd=%h, want 12345678 00", ctrl_o, cmd_o);
      n_errors++;
    end
  endtask

  task automatic test_ext();
    int stray_acks;
    stray_acks = 0;
    @(negedge clk);
    ext_ack   = 1'b1;
    ext_rdata = 32'h1111_2222;
    @(negedge clk);
    ext_ack = 1'b0;
    stray_acks += int'(host_ack);
    @(negedge clk);
    stray_acks += int'(host_ack);
    n_checks++;
    if (stray_acks != 0 || ext_req !== 1'b0) begin
      $display("FAIL ext_ack_idle: got %0d acks ext_req=%b, want 0 0", stray_acks, ext_req);
      n_errors++;
    end
    ext_access(1'b1, 10'h200, 32'h0, 5, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 7, "ext_read");
    ext_access(1'b0, 10'h204, 32'h0000_55AA, 1, 32'hFFFF_FFFF, 32'h0, 1'b0, 3, "ext_write");
    ext_access(1'b1, 10'h3F0, 32'h0, 0, 32'h0, 32'hDEAD_BEEF, 1'b1, EXT_TIMEOUT + 2,
               "ext_timeout");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cyc;
    int   ack_cycles[$];
    e.lat = 8'd1; e.err = 1'b0; e.rdata = ID_VALUE;
    sb_q.push_back(e);
    e.lat = 8'd2; e.rdata = 32'h1234_5678;
    sb_q.push_back(e);
    @(negedge clk);
    host_req  = 1'b1;
    host_rnw  = 1'b1;
    host_addr = 10'h000;
    cyc = 0;
    while (ack_cycles.size() < 2 && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (host_ack) begin
        score(1'b1, (ack_cycles.size() == 0) ? cyc : cyc - ack_cycles[0],
              (ack_cycles.size() == 0) ? "b2b_first" : "b2b_second");
        ack_cycles.push_back(cyc);
        host_addr = 10'h004;
        if (ack_cycles.size() == 2) host_req = 1'b0;
      end
    end
    host_req = 1'b0;
    if (ack_cycles.size() < 2) begin
      while (sb_q.size() > 0) score(1'b0, cyc, "b2b_missing");
    end
    check_ack_drop("b2b");
  endtask

  task automatic test_reset_mid_ext();
    int acks_seen;
    acks_seen = 0;
    @(negedge clk);
    host_req  = 1'b1;
    host_rnw  = 1'b1;
    host_addr = 10'h300;
    repeat (10) begin
      @(negedge clk);
      acks_seen += int'(host_ack);
    end
    n_checks++;
    if (ext_req !== 1'b1) begin
      $display("FAIL mid_ext_pending: got ext_req=%b, want 1", ext_req);
      n_errors++;
    end
    #2 sys_reset_n = 1'b0;
    #1;
    n_checks++;
    if ({ext_req, host_ack, host_rdata, host_err, ctrl_o, cmd_o, trig_o} !== '0) begin
      $display("FAIL mid_ext_reset: got ext_req=%b ack=%b ctrl=%h, want all 0",
               ext_req, host_ack, ctrl_o);
      n_errors++;
    end
    host_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      acks_seen += int'(host_ack) + int'(ext_req);
    end
    sys_reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      acks_seen += int'(host_ack) + int'(ext_req);
    end
    n_checks++;
    if (acks_seen != 0) begin
      $display("FAIL mid_ext_no_ack: got %0d ack/req cycles, want 0", acks_seen);
      n_errors++;
    end
    host_access(1'b1, 10'h000, 32'h0, 8'h00, 8'h00, ID_VALUE, 1'b0, "post_reset_id");
    host_access(1'b1, 10'h004, 32'h0, 8'h00, 8'h00, 32'h0, 1'b0, "post_reset_ctrl");
  endtask

  initial begin
    test_reset();
    test_id_ctrl();
    test_status();
    test_cmd();
    test_trig_unmapped();
    test_ext();
    test_back_to_back();
    test_reset_mid_ext();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fdk_regbank_slave.md
# fdk_regbank_slave

Synthesizable register bank that implements the FDK register-file semantics (RW, RO, WO, RW2C, RW2S fields plus an external section) behind a single-master host request/acknowledge bus. It sits between the host bus decoder and the core logic, and it is the RTL the FDK register-model package mirrors and checks. Internal registers are answered locally. Addresses in the upper half of the space are forwarded to an external section port with a bounded wait.

## Interface
- ADDR_W, 10: byte address width; bit ADDR_W-1 = 1 selects the external section.
- ID_VALUE, 32'h0A7E_0001: constant returned by the ID register.
- EXT_TIMEOUT, 64: maximum cycles to wait for ext_ack before aborting an external access.
- sys_clk  in  1  single clock, rising edge.
- sys_reset_n  in  1  asynchronous active-low reset.
- host_req  in  1  access request; held until host_ack.
- host_rnw  in  1  1 = read, 0 = write; stable while host_req is high.
- host_addr  in  ADDR_W  byte address, 32-bit aligned; bits [1:0] are ignored.
- host_wdata  in  32  write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  32  read data, valid when host_ack is high, otherwise 0.
- host_err  out  1  qualifies host_ack: the access was unmapped or timed out.
- ctrl_o  out  32  CTRL register (RW).
- cmd_o  out  8  CMD register (RW2S).
- cmd_done_i  in  8  per-bit pulses from the core that clear cmd_o bits.
- event_i  in  8  per-bit pulses from the core that set STATUS bits.
- trig_o  out  8  one-cycle pulses produced by writes to TRIG (WO).
- ext_req  out  1  external access request.
- ext_rnw, ext_addr[ADDR_W-2:0], ext_wdata[31:0]  out  external access qualifiers, stable while ext_req is high.
- ext_ack  in  1  external completion pulse.
- ext_rdata  in  32  external read data, valid with ext_ack.

## Operation
- Register map. Offsets are in the lower half of the space.
  - 0x000 ID: RO, reads ID_VALUE; writes are ignored.
  - 0x004 CTRL: RW, 32 bits, reset 0.
  - 0x008 STATUS: RW2C, bits [7:0]. A pulse on event_i[n] sets bit n; a host write of 1 to bit n clears it; bits [31:8] read 0.
  - 0x00C CMD: RW2S, bits [7:0]. A host write of 1 to bit n sets it; a cmd_done_i[n] pulse clears it.
  - 0x010 TRIG: WO. A write pulses trig_o = wdata[7:0] for one cycle; reads return 0.
  - Any other lower-half offset is unmapped: reads return 0, writes have no effect, and the ack carries host_err = 1.
- FSM states: IDLE, EXT_WAIT, DONE.
  - IDLE, host_req = 1, internal address: the access is performed in that cycle; next state DONE with host_ack = 1.
  - IDLE, host_req = 1, external address: next state EXT_WAIT; ext_req and its qualifiers are registered.
  - EXT_WAIT: ext_req is held. On ext_ack, host_rdata = ext_rdata (read) and host_err = 0, then DONE with host_ack. When the wait counter reaches EXT_TIMEOUT, ext_req drops, host_rdata = 32'hDEAD_BEEF and host_err = 1, then DONE with host_ack.
  - DONE: host_ack is high for this cycle only. Next state IDLE unconditionally; host_req is not sampled in DONE.
- Conflicts on the same bit in the same cycle:
  - event_i set beats host write-1-clear.
  - host write-1-set beats cmd_done_i clear.
- An ext_ack that arrives outside EXT_WAIT is ignored.

## Timing
- Reset values: all outputs 0, FSM in IDLE, wait counter 0. The wait counter is $clog2(EXT_TIMEOUT+1) bits.
- Internal access: host_req sampled high in cycle N gives host_ack in cycle N+1, with rdata and err registered.
- Register updates:
  - A write to CTRL or CMD is visible on ctrl_o / cmd_o in N+1.
  - trig_o pulses in N+1.
- External access, req sampled in N:
  - ext_req rises in N+1.
  - ext_ack in cycle M gives host_ack in M+1, and ext_req is low in M+1.
  - Timeout: host_ack in N+1+EXT_TIMEOUT+1.
- Back-to-back accesses: the minimum spacing between acks is 2 cycles.
- An asynchronous reset mid-access returns the FSM to IDLE and drops ext_req immediately. No ack is issued for the aborted access.

## Test plan
- Reset, then read 0x000 -> ack one cycle after req, rdata 0x0A7E0001, err 0. Write 0x004 = 0x12345678 -> ctrl_o = 0x12345678; read back matches.
- event_i = 0x05 pulse; read 0x008 -> 0x05. Write 0x008 = 0x01 -> STATUS 0x04. Same-cycle event_i[2] pulse and write 0x04 -> bit 2 stays 1.
- Write 0x00C = 0x81 -> cmd_o = 0x81. cmd_done_i = 0x01 -> cmd_o = 0x80. Same-cycle write 0x80 and cmd_done_i[7] -> cmd_o[7] stays 1.
- Write 0x010 = 0xA5 -> trig_o = 0xA5 for exactly one cycle; read 0x010 -> 0. Read 0x014 -> rdata 0, err 1.
- External read at 0x200, responder acks after 5 cycles with 0xCAFEF00D -> host_rdata 0xCAFEF00D, err 0, ack 7 cycles after req. With no responder -> rdata 0xDEADBEEF, err 1, ack EXT_TIMEOUT+2 cycles after req.
- Assert reset during EXT_WAIT -> ext_req low immediately, no host_ack, all outputs 0. The next access after reset completes normally.
